// File: rtl/duc_stream_pkg.sv
// Shared types and constants for the DUC ready-only stream source.
//   state_e  : source FSM states (prime the FIFO cushion, or stream).
//   UF_CNT_W : width of the saturating underflow event counter.
package duc_stream_pkg;

  typedef enum logic {
    ST_PRIME  = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  localparam int UF_CNT_W = 16;

endpackage

// File: rtl/duc_stream_fifo_mem.sv
// Sample storage for the stream source FIFO: 2^DEPTH_LOG2 x WIDTH registers.
// Ports:
//   i_clock  : write clock (rising edge)
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address
//   o_rdata  : combinational read data at i_raddr
// Contents are not reset; the owning FIFO's pointers define what is valid.
module duc_stream_fifo_mem #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_clock,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [WIDTH-1:0]      i_wdata,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output logic [WIDTH-1:0]      o_rdata
);

  logic [WIDTH-1:0] mem_q [2**DEPTH_LOG2];

  always_ff @(posedge i_clock) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/duc_stream_source.sv
// Transmit end of the DUC ready-only sample stream.
// A producer writes valid-tagged samples into a small FIFO. The consumer has
// no valid qualifier: it takes o_out_data at every edge where i_out_ready=1.
// The source therefore first primes PRIME_LEVEL samples of cushion, then
// streams; if starved while streaming it emits zero, counts an underflow and
// re-primes.
// Ports:
//   i_clock, i_reset_n       : clock, async active-low reset
//   i_in_data, i_in_valid    : producer sample and its valid
//   o_in_ready               : registered FIFO-not-full (next level < depth)
//   o_out_data, i_out_ready  : registered consumer sample, consumer take strobe
//   o_streaming              : 1 while in ST_STREAM (FSM state visibility)
//   o_level                  : FIFO occupancy 0..2^DEPTH_LOG2
//   o_underflow              : sticky underflow flag
//   o_underflow_count        : saturating underflow event count
//   i_clear_underflow        : synchronous clear of flag and count
// Handshake: producer side is valid/ready -- a sample transfers at an edge
// where i_in_valid && o_in_ready; a producer seeing o_in_ready=0 must hold
// its sample. Consumer side is ready-only -- o_out_data is consumed at every
// edge with i_out_ready=1, whether or not it carries real data.
module duc_stream_source
  import duc_stream_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DEPTH_LOG2  = 4,
  parameter int PRIME_LEVEL = 8   // legal range 1..2^DEPTH_LOG2
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic [WIDTH-1:0]      i_in_data,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  output logic [WIDTH-1:0]      o_out_data,
  input  logic                  i_out_ready,
  output logic                  o_streaming,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic                  o_underflow,
  output logic [UF_CNT_W-1:0]   o_underflow_count,
  input  logic                  i_clear_underflow
);

  localparam int                    DEPTH     = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_LVL  = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   PRIME_LVL = (DEPTH_LOG2+1)'(PRIME_LEVEL);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE   = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
  localparam logic [UF_CNT_W-1:0]   CNT_ONE   = UF_CNT_W'(1);

  state_e                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]     level_q, level_d;
  logic                    in_ready_q, in_ready_d;
  logic [WIDTH-1:0]        out_data_q, out_data_d;
  logic                    uf_flag_q, uf_flag_d;
  logic [UF_CNT_W-1:0]     uf_count_q, uf_count_d;

  logic                    push;
  logic                    pop;
  logic                    uf_event;
  logic [WIDTH-1:0]        rd_data;

  assign push = i_in_valid && in_ready_q;

  duc_stream_fifo_mem #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .i_clock (i_clock),
    .i_we    (push),
    .i_waddr (wr_ptr_q),
    .i_wdata (i_in_data),
    .i_raddr (rd_ptr_q),
    .o_rdata (rd_data)
  );

  // FSM next state and output sample. Pops are decided from the registered
  // level only, so a sample written at this edge is never popped at it.
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    pop        = 1'b0;
    uf_event   = 1'b0;
    case (state_q)
      ST_PRIME: begin
        out_data_d = '0;
        // i_out_ready is deliberately ignored on the priming pop.
        if (level_q >= PRIME_LVL) begin
          pop        = 1'b1;
          out_data_d = rd_data;
          state_d    = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (i_out_ready) begin
          if (level_q != '0) begin
            pop        = 1'b1;
            out_data_d = rd_data;
          end else begin
            uf_event   = 1'b1;
            out_data_d = '0;
            state_d    = ST_PRIME;
          end
        end
      end
      default: begin
        state_d    = ST_PRIME;
        out_data_d = '0;
      end
    endcase
  end

  // FIFO bookkeeping.
  always_comb begin
    wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
    in_ready_d = (level_d < FULL_LVL);
  end

  // Underflow flag/counter. A clear coinciding with an event leaves exactly
  // that one event recorded.
  always_comb begin
    uf_flag_d  = uf_flag_q;
    uf_count_d = uf_count_q;
    if (i_clear_underflow) begin
      uf_flag_d  = uf_event;
      uf_count_d = uf_event ? CNT_ONE : '0;
    end else if (uf_event) begin
      uf_flag_d = 1'b1;
      if (uf_count_q != '1) begin
        uf_count_d = uf_count_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_PRIME;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      in_ready_q <= 1'b0;
      out_data_q <= '0;
      uf_flag_q  <= 1'b0;
      uf_count_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      in_ready_q <= in_ready_d;
      out_data_q <= out_data_d;
      uf_flag_q  <= uf_flag_d;
      uf_count_q <= uf_count_d;
    end
  end

  assign o_in_ready        = in_ready_q;
  assign o_out_data        = out_data_q;
  assign o_streaming       = (state_q == ST_STREAM);
  assign o_level           = level_q;
  assign o_underflow       = uf_flag_q;
  assign o_underflow_count = uf_count_q;

endmodule

// File: tb/tb_duc_stream_source.sv
// Bench for duc_stream_source: a hand-computed vector table for prime,
// drain, underflow and restart, explicit back-pressure / full / counter /
// async-reset sequences, and a randomized phase, all tracked by a
// queue-based reference model of the stream source.
module tb_duc_stream_source;

  localparam int WIDTH       = 16;
  localparam int DEPTH_LOG2  = 4;
  localparam int PRIME_LEVEL = 8;
  localparam int DEPTH       = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n = 1'b0;
  logic [WIDTH-1:0]    in_data = '0;
  logic                in_valid = 1'b0;
  logic                out_ready = 1'b0;
  logic                clear_uf = 1'b0;
  logic                in_ready;
  logic [WIDTH-1:0]    out_data;
  logic                streaming;
  logic [DEPTH_LOG2:0] level;
  logic                underflow;
  logic [15:0]         uf_count;

  duc_stream_source #(
    .WIDTH       (WIDTH),
    .DEPTH_LOG2  (DEPTH_LOG2),
    .PRIME_LEVEL (PRIME_LEVEL)
  ) dut (
    .i_clock           (clk),
    .i_reset_n         (rst_n),
    .i_in_data         (in_data),
    .i_in_valid        (in_valid),
    .o_in_ready        (in_ready),
    .o_out_data        (out_data),
    .i_out_ready       (out_ready),
    .o_streaming       (streaming),
    .o_level           (level),
    .o_underflow       (underflow),
    .o_underflow_count (uf_count),
    .i_clear_underflow (clear_uf)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] exp_q[$];   // samples held by the FIFO, oldest first
  bit               m_stream;
  logic [WIDTH-1:0] m_out;
  bit               m_in_ready;
  bit               m_uf;
  int               m_cnt;
  bit               m_uf_evt;   // an underflow happened at the last edge

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_stream   = 0;
    m_out      = '0;
    m_in_ready = 0;
    m_uf       = 0;
    m_cnt      = 0;
    m_uf_evt   = 0;
  endtask

  // One rising edge of the source, from the rules: prime when cushion is
  // reached, stream one sample per ready edge, zero + underflow when empty.
  task automatic model_step();
    bit push;
    push     = in_valid && m_in_ready;
    m_uf_evt = 0;
    if (!m_stream) begin
      if (exp_q.size() >= PRIME_LEVEL) begin
        m_out    = exp_q.pop_front();
        m_stream = 1;
      end
    end else if (out_ready) begin
      if (exp_q.size() > 0) begin
        m_out = exp_q.pop_front();
      end else begin
        m_uf_evt = 1;
        m_out    = '0;
        m_stream = 0;
      end
    end
    if (clear_uf) begin
      m_uf  = m_uf_evt;
      m_cnt = m_uf_evt ? 1 : 0;
    end else if (m_uf_evt) begin
      m_uf  = 1;
      m_cnt = (m_cnt == 65535) ? 65535 : m_cnt + 1;
    end
    if (push) exp_q.push_back(in_data);
    m_in_ready = (exp_q.size() < DEPTH);
  endtask

  task automatic check_model();
    chk("out_data",  32'(out_data),  32'(m_out));
    chk("in_ready",  32'(in_ready),  32'(m_in_ready));
    chk("level",     32'(level),     32'(exp_q.size()));
    chk("streaming", 32'(streaming), 32'(m_stream));
    chk("underflow", 32'(underflow), 32'(m_uf));
    chk("uf_count",  32'(uf_count),  32'(m_cnt));
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic drive(input bit v, input logic [WIDTH-1:0] d, input bit r, input bit c);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    clear_uf  = c;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_out_data"},  32'(out_data),  32'h0);
    chk({tag, "_in_ready"},  32'(in_ready),  32'h0);
    chk({tag, "_level"},     32'(level),     32'h0);
    chk({tag, "_streaming"}, 32'(streaming), 32'h0);
    chk({tag, "_underflow"}, 32'(underflow), 32'h0);
    chk({tag, "_uf_count"},  32'(uf_count),  32'h0);
  endtask

  task automatic do_reset();
    drive(0, '0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("rst");
    rst_n = 1'b1;
    model_reset();
  endtask

  // Fill PRIME_LEVEL samples, then consume until the model sees an
  // underflow; optionally assert clear on exactly that edge.
  task automatic run_to_underflow(input bit clear_on_uf, input string tag);
    bit seen;
    seen = 0;
    for (int k = 0; k < PRIME_LEVEL; k++) begin
      drive(1, WIDTH'($urandom), 0, 0);
      cycle();
    end
    for (int k = 0; k < 24 && !seen; k++) begin
      drive(0, '0, 1, clear_on_uf && m_stream && exp_q.size() == 0);
      cycle();
      seen = m_uf_evt;
    end
    drive(0, '0, 0, 0);
    chk({tag, "_uf_seen"}, 32'(seen), 32'h1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit               valid;
    logic [WIDTH-1:0] data;
    bit               ready;
    logic [WIDTH-1:0] e_out;
    int               e_level;
    bit               e_stream;
    bit               e_uf;
    int               e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit v, input logic [WIDTH-1:0] d, input bit r,
                              input logic [WIDTH-1:0] eo, input int el,
                              input bit es, input bit eu, input int ec);
    vec_t t;
    t.valid = v; t.data = d; t.ready = r;
    t.e_out = eo; t.e_level = el; t.e_stream = es; t.e_uf = eu; t.e_cnt = ec;
    vecs.push_back(t);
  endfunction

  // ---------------- test ----------------
  int acc;
  int guard;

  initial begin
    // Prime 0x0001..0x0008 with ready held, drain, underflow, restart.
    add(0, 16'h0, 1, 16'h0, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++) add(1, 16'(k), 1, 16'h0, k, 0, 0, 0);
    add(0, 16'h0, 1, 16'h1, 7, 1, 0, 0);
    for (int k = 2; k <= 8; k++) add(0, 16'h0, 1, 16'(k), 8 - k, 1, 0, 0);
    add(0, 16'h0, 1, 16'h0, 0, 0, 1, 1);
    add(0, 16'h0, 1, 16'h0, 0, 0, 1, 1);
    for (int k = 1; k <= 8; k++) add(1, 16'(16'h10 + k), 1, 16'h0, k, 0, 1, 1);
    add(0, 16'h0, 1, 16'h11, 7, 1, 1, 1);
    add(0, 16'h0, 1, 16'h12, 6, 1, 1, 1);

    do_reset();
    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].data, vecs[i].ready, 0);
      cycle();
      chk("tbl_out_data",  32'(out_data),  32'(vecs[i].e_out));
      chk("tbl_level",     32'(level),     32'(vecs[i].e_level));
      chk("tbl_streaming", 32'(streaming), 32'(vecs[i].e_stream));
      chk("tbl_underflow", 32'(underflow), 32'(vecs[i].e_uf));
      chk("tbl_uf_count",  32'(uf_count),  32'(vecs[i].e_cnt));
      chk("tbl_in_ready",  32'(in_ready),  32'h1);
    end

    // Back-pressure 1,0,0,1: 0x13 shown and held, then 0x14.
    drive(0, '0, 1, 0); cycle(); chk("bp_take",  32'(out_data), 32'h13);
    drive(0, '0, 0, 0); cycle(); chk("bp_hold1", 32'(out_data), 32'h13);
    drive(0, '0, 0, 0); cycle(); chk("bp_hold2", 32'(out_data), 32'h13);
    drive(0, '0, 1, 0); cycle(); chk("bp_next",  32'(out_data), 32'h14);
    chk("bp_level", 32'(level), 32'h4);

    // Full: producer holds each sample until accepted; consumer stalled.
    acc = 0;
    for (int k = 0; k < 30 && in_ready; k++) begin
      drive(1, 16'(16'h100 + acc), 0, 0);
      guard = int'(in_ready);
      cycle();
      acc += guard;
    end
    chk("full_level",    32'(level),    32'h10);
    chk("full_in_ready", 32'(in_ready), 32'h0);
    chk("full_accepted", 32'(acc),      32'hC);
    drive(1, 16'(16'h100 + acc), 0, 0);
    cycle();
    chk("full_drop_level", 32'(level), 32'h10);
    drive(1, 16'(16'h100 + acc), 1, 0);
    cycle();
    chk("full_pop_out",   32'(out_data), 32'h15);
    chk("full_pop_level", 32'(level),    32'hF);
    chk("full_pop_ready", 32'(in_ready), 32'h1);
    drive(1, 16'(16'h100 + acc), 1, 0);
    cycle();
    acc++;
    chk("pushpop_level", 32'(level),    32'hF);
    chk("pushpop_out",   32'(out_data), 32'h16);
    drive(1, 16'(16'h100 + acc), 0, 0);
    cycle();
    chk("refill_level", 32'(level), 32'h10);

    // Randomized traffic against the model.
    for (int k = 0; k < 2000; k++) begin
      drive(1'($urandom_range(0, 1)), WIDTH'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
      cycle();
    end

    // Asynchronous reset mid-stream, then re-prime from empty.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      drive(1, WIDTH'($urandom), 1, 0);
      cycle();
    end
    chk("mid_streaming", 32'(streaming), 32'h1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_values("async");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    drive(0, '0, 1, 0);
    cycle();
    for (int k = 0; k < PRIME_LEVEL; k++) begin
      drive(1, WIDTH'($urandom), 1, 0);
      cycle();
    end
    drive(0, '0, 1, 0);
    cycle();
    chk("reprime_streaming", 32'(streaming), 32'h1);
    chk("reprime_level",     32'(level),     32'(PRIME_LEVEL - 1));

    // Counter saturation: preload 0xFFFE, then two underflows, then a
    // clear coincident with an underflow.
    do_reset();
    force dut.uf_count_q = 16'hFFFE;
    m_cnt = 16'hFFFE;
    cycle();
    release dut.uf_count_q;
    cycle();
    chk("preload_count", 32'(uf_count), 32'hFFFE);
    run_to_underflow(0, "sat1");
    chk("sat1_count", 32'(uf_count),  32'hFFFF);
    chk("sat1_flag",  32'(underflow), 32'h1);
    run_to_underflow(0, "sat2");
    chk("sat2_count", 32'(uf_count),  32'hFFFF);
    run_to_underflow(1, "clr");
    chk("clr_count", 32'(uf_count),  32'h1);
    chk("clr_flag",  32'(underflow), 32'h1);
    drive(0, '0, 0, 1);
    cycle();
    chk("clr_only_count", 32'(uf_count),  32'h0);
    chk("clr_only_flag",  32'(underflow), 32'h0);
    drive(0, '0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
